// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: SRAM access sequencing with wait states plus the
// memory-mapped keyboard (KBSR/KBDR) and display (DSR/DDR) registers.
module lc3_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MAR,
  input  logic        ldMAR,
  input  logic [15:0] MDR_in,
  input  logic        memWE,
  output logic [15:0] memOut,
  output logic        memRDY,
  output logic [15:0] sram_addr,
  output logic        sram_re,
  output logic        sram_we,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready,
  output logic        kbdINT
);

  typedef enum logic [1:0] {StIdle, StWait, StRead, StReady} state_e;

  localparam logic [15:0] DevBase  = 16'hFE00;
  localparam logic [15:0] AddrKbsr = 16'hFE00;
  localparam logic [15:0] AddrKbdr = 16'hFE02;
  localparam logic [15:0] AddrDsr  = 16'hFE04;
  localparam logic [15:0] AddrDdr  = 16'hFE06;
  // Guarded so WAIT_CYCLES=0 does not wrap when computing the preload.
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] memout_q, memout_d;
  logic        kbsr15_q, kbsr15_d;
  logic        kbsr14_q, kbsr14_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        dsr15_q, dsr15_d;
  logic [7:0]  ddr_q, ddr_d;
  logic        dsp_valid_q, dsp_valid_d;

  logic [15:0] dev_rdata;
  logic        cur_dev, mar_dev, wr_fire, kbdr_read, kbd_take;

  assign cur_dev   = (addr_q >= DevBase);
  assign mar_dev   = (MAR >= DevBase);
  assign wr_fire   = (state_q == StReady) && memWE && !rst;
  assign kbdr_read = ldMAR && (MAR == AddrKbdr);
  // A KBDR read consumes the held character, so a same-cycle strobe may refill it.
  assign kbd_take  = kbd_valid && (!kbsr15_q || kbdr_read);

  assign memOut     = memout_q;
  assign memRDY     = (state_q == StReady);
  assign sram_addr  = addr_q;
  assign sram_re    = (state_q == StRead) && !rst;
  assign sram_we    = wr_fire && !cur_dev;
  assign sram_wdata = sram_we ? MDR_in : 16'h0000;
  assign dsp_valid  = dsp_valid_q;
  assign dsp_data   = ddr_q;
  assign kbdINT     = kbsr15_q & kbsr14_q;

  // Device register read mux, addressed by the incoming MAR value.
  always_comb begin
    dev_rdata = 16'h0000;
    case (MAR)
      AddrKbsr: dev_rdata = {kbsr15_q, kbsr14_q, 14'b0};
      AddrKbdr: dev_rdata = {8'h00, kbdr_q};
      AddrDsr:  dev_rdata = {dsr15_q, 15'b0};
      AddrDdr:  dev_rdata = {8'h00, ddr_q};
      default:  dev_rdata = 16'h0000;
    endcase
  end

  // Next-state: access FSM, device writes, keyboard and display handshakes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    memout_d    = memout_q;
    kbsr15_d    = kbsr15_q;
    kbsr14_d    = kbsr14_q;
    kbdr_d      = kbdr_q;
    dsr15_d     = dsr15_q;
    ddr_d       = ddr_q;
    dsp_valid_d = dsp_valid_q;

    if (dsp_valid_q && dsp_ready) begin
      dsp_valid_d = 1'b0;
      dsr15_d     = 1'b1;
    end

    if (kbd_take) begin
      kbdr_d   = kbd_data;
      kbsr15_d = 1'b1;
    end else if (kbdr_read) begin
      kbsr15_d = 1'b0;
    end

    // Writes commit against the current address before any new access starts.
    if (wr_fire) begin
      if (!cur_dev) begin
        memout_d = MDR_in;
      end else if (addr_q == AddrKbsr) begin
        kbsr14_d = MDR_in[14];
      end else if (addr_q == AddrDdr) begin
        ddr_d       = MDR_in[7:0];
        dsr15_d     = 1'b0;
        dsp_valid_d = 1'b1;
      end
    end

    if (ldMAR) begin
      addr_d = MAR;
      cnt_d  = 4'd0;
      if (mar_dev) begin
        state_d  = StReady;
        memout_d = dev_rdata;
      end else if (WAIT_CYCLES > 0) begin
        state_d = StWait;
        cnt_d   = WaitInit;
      end else begin
        state_d = StRead;
      end
    end else begin
      case (state_q)
        StWait: begin
          if (cnt_q == 4'd0) state_d = StRead;
          else cnt_d = cnt_q - 4'd1;
        end
        StRead: begin
          state_d  = StReady;
          memout_d = sram_rdata;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= 16'h0000;
      memout_q    <= 16'h0000;
      kbsr15_q    <= 1'b0;
      kbsr14_q    <= 1'b0;
      kbdr_q      <= 8'h00;
      dsr15_q     <= 1'b1;
      ddr_q       <= 8'h00;
      dsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      memout_q    <= memout_d;
      kbsr15_q    <= kbsr15_d;
      kbsr14_q    <= kbsr14_d;
      kbdr_q      <= kbdr_d;
      dsr15_q     <= dsr15_d;
      ddr_q       <= ddr_d;
      dsp_valid_q <= dsp_valid_d;
    end
  end

endmodule
